// File: rtl/ahb_spi_pkg.sv
// Shared definitions for the AHB-to-SPI bridge: request word layout and
// the SPI master state encoding.
package ahb_spi_pkg;

  localparam int FRAME_W  = 41;
  localparam int RW_BIT   = 40;
  localparam int ADDR_MSB = 39;
  localparam int ADDR_LSB = 32;
  localparam int DATA_MSB = 31;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4,
    PUSH  = 3'd5,
    GAP   = 3'd6
  } spi_state_t;

endpackage

// File: rtl/spi_master_ctrl_clk_gen.sv
// SCLK divider: toggles SCLK every CLK_DIV cycles while enabled, and reports
// which edge the next toggle produces so the master can act on it.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb,
  output logic cnt_done
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign cnt_done = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_stb = cnt_done && !sclk;
  assign fall_stb = cnt_done && sclk;

  // Disabling parks SCLK low and restarts the half-period count.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (cnt_done) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: pops request words from the TxFIFO, runs one frame per
// word and pushes the 32-bit response of read frames into the RxFIFO.
module spi_master_ctrl
  import ahb_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  localparam int FW     = 1 + ADDR_W + DATA_W
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [FW-1:0]     DATA_from_TxFIFO,
  input  logic              TxFIFO_empty,
  output logic              TxFIFO_rd_en,
  output logic [DATA_W-1:0] DATA_to_RxFIFO,
  output logic              RxFIFO_wr_en,
  input  logic              RxFIFO_full,
  output logic              SCLK,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO,
  output logic              busy,
  output spi_state_t        state_dbg
);

  localparam int FCW = $clog2(FW + 1);
  localparam int WCW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  spi_state_t        state, state_nx;
  logic [FW-1:0]     tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [FCW-1:0]    fall_cnt;
  logic [WCW-1:0]    wait_cnt;
  logic              rw_q;
  logic              shift_en, rise_stb, fall_stb, cnt_done;
  logic              last_fall, wait_en, wait_done, pop_ok, push_ok;

  assign shift_en  = (state == SHIFT);
  assign last_fall = cnt_done && SCLK && (fall_cnt == FCW'(FW - 1));
  assign wait_en   = (state == HOLD) || (state == GAP);
  assign wait_done = wait_en && (wait_cnt == WCW'(CLK_DIV - 1));
  assign pop_ok    = (state == IDLE) && !TxFIFO_empty;
  assign push_ok   = (state == PUSH) && !RxFIFO_full;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .en       (shift_en),
    .sclk     (SCLK),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .cnt_done (cnt_done)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!TxFIFO_empty) state_nx = POP;
      POP:     state_nx = LOAD;
      LOAD:    state_nx = SHIFT;
      SHIFT:   if (last_fall) state_nx = HOLD;
      HOLD:    if (wait_done) state_nx = rw_q ? GAP : PUSH;
      PUSH:    if (!RxFIFO_full) state_nx = GAP;
      GAP:     if (wait_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FIFO handshake: TxFIFO_rd_en and RxFIFO_wr_en are single-cycle strobes,
  // each issued only when the FIFO flag seen in the previous cycle allows it.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      TxFIFO_rd_en   <= 1'b0;
      RxFIFO_wr_en   <= 1'b0;
      DATA_to_RxFIFO <= '0;
    end else begin
      TxFIFO_rd_en <= pop_ok;
      RxFIFO_wr_en <= push_ok;
      if (push_ok) DATA_to_RxFIFO <= rx_shift;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wait_cnt <= '0;
    end else if (wait_en && !wait_done) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Read frames send only rw+addr; the data field goes out as zeros.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      tx_shift <= '0;
      rx_shift <= '0;
      fall_cnt <= '0;
      rw_q     <= 1'b0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          tx_shift <= DATA_from_TxFIFO[FW-1] ? DATA_from_TxFIFO
                      : {DATA_from_TxFIFO[FW-1:DATA_W], {DATA_W{1'b0}}};
          rw_q     <= DATA_from_TxFIFO[FW-1];
          rx_shift <= '0;
          fall_cnt <= '0;
          SS_n     <= 1'b0;
          MOSI     <= DATA_from_TxFIFO[FW-1];
        end
        SHIFT: begin
          if (rise_stb) rx_shift <= {rx_shift[DATA_W-2:0], MISO};
          if (last_fall) begin
            MOSI <= 1'b0;
          end else if (fall_stb) begin
            tx_shift <= {tx_shift[FW-2:0], 1'b0};
            MOSI     <= tx_shift[FW-2];
            fall_cnt <= fall_cnt + 1'b1;
          end
        end
        HOLD: if (wait_done) SS_n <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: TxFIFO model, SPI slave/monitor with a frame-level
// reference model, and an RxFIFO scoreboard.
module tb_spi_master_ctrl;
  import ahb_spi_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int FW      = 41;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic [FW-1:0] TxFIFO_dout = '0;
  logic          TxFIFO_empty = 1'b1;
  logic          TxFIFO_rd_en;
  logic [31:0]   DATA_to_RxFIFO;
  logic          RxFIFO_wr_en;
  logic          RxFIFO_full = 1'b0;
  logic          SCLK, SS_n, MOSI;
  logic          MISO = 1'b0;
  logic          busy;
  spi_state_t    state_dbg;

  spi_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .HCLK             (HCLK),
    .HRESET           (HRESET),
    .DATA_from_TxFIFO (TxFIFO_dout),
    .TxFIFO_empty     (TxFIFO_empty),
    .TxFIFO_rd_en     (TxFIFO_rd_en),
    .DATA_to_RxFIFO   (DATA_to_RxFIFO),
    .RxFIFO_wr_en     (RxFIFO_wr_en),
    .RxFIFO_full      (RxFIFO_full),
    .SCLK             (SCLK),
    .SS_n             (SS_n),
    .MOSI             (MOSI),
    .MISO             (MISO),
    .busy             (busy),
    .state_dbg        (state_dbg)
  );

  // clock / watchdog
  always #5 HCLK = ~HCLK;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // TxFIFO model: words written by the driver, read data valid the cycle after rd_en
  logic [FW-1:0] tx_mem [0:63];
  logic [31:0]   resp_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_err = 0;

  initial begin
    forever begin
      @(posedge HCLK);
      if (TxFIFO_rd_en) begin
        if (rd_ptr == wr_ptr) pop_err++;
        else begin
          TxFIFO_dout <= tx_mem[rd_ptr];
          rd_ptr++;
        end
      end
      TxFIFO_empty <= (rd_ptr == wr_ptr);
    end
  end

  task automatic push_word(input logic [FW-1:0] w, input logic [31:0] resp);
    tx_mem[wr_ptr]   = w;
    resp_mem[wr_ptr] = resp;
    wr_ptr++;
  endtask

  // reference model: what a frame must put on MOSI, and the MISO bit for rising edge k
  function automatic logic [FW-1:0] exp_frame(input logic [FW-1:0] w);
    logic [FW-1:0] f;
    f = w;
    if (!w[FW-1]) f[31:0] = '0;
    return f;
  endfunction

  logic [FW-1:0] cur_word;
  logic [31:0]   cur_resp;

  function automatic logic miso_for(input int k);
    int idx;
    if (k > FW) return 1'b0;
    if (k <= 9) return 1'($urandom_range(0, 1));
    idx = FW - k;
    return cur_resp[idx];
  endfunction

  // SPI slave + frame monitor
  bit  in_frame  = 0;
  bit  prev_sclk = 0;
  int  rises = 0, lo_run = 0, hi_run = 0, ss_hi = 0, frames = 0, fr_ptr = 0;
  int  n_push = 0, proto_err = 0, duty_err = 0, gap_err = 0;
  logic [FW-1:0] mosi_cap;
  logic [31:0]   exp_w;

  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        in_frame  = 0;
        prev_sclk = 0;
        ss_hi     = 0;
        MISO      = 1'b0;
      end else begin
        if (RxFIFO_wr_en) begin
          n_push++;
          if (RxFIFO_full) proto_err++;
          if (exp_q.size() == 0) chk("rx_unexpected", 1, 0);
          else begin
            exp_w = exp_q.pop_front();
            chk("rx_data", DATA_to_RxFIFO, exp_w);
          end
        end
        if (TxFIFO_rd_en && TxFIFO_empty) proto_err++;
        if (SS_n && SCLK) proto_err++;
        if (!SS_n && !in_frame) begin
          in_frame = 1;
          rises    = 0;
          lo_run   = 0;
          hi_run   = 0;
          mosi_cap = '0;
          if (frames > 0 && ss_hi < CLK_DIV) gap_err++;
          if (fr_ptr < wr_ptr) begin
            cur_word = tx_mem[fr_ptr];
            cur_resp = resp_mem[fr_ptr];
            fr_ptr++;
          end else proto_err++;
          MISO = miso_for(1);
        end
        if (in_frame && !SS_n) begin
          if (SCLK) begin
            if (!prev_sclk) begin
              rises++;
              mosi_cap = {mosi_cap[FW-2:0], MOSI};
              if (lo_run != CLK_DIV) duty_err++;
              lo_run = 0;
            end
            hi_run++;
          end else begin
            if (prev_sclk) begin
              if (hi_run != CLK_DIV) duty_err++;
              hi_run = 0;
              MISO = miso_for(rises + 1);
            end
            lo_run++;
          end
        end else if (in_frame && SS_n) begin
          in_frame = 0;
          frames++;
          chk("rise_cnt", rises, FW);
          chk("mosi_stream", mosi_cap, exp_frame(cur_word));
          chk("hold_low", lo_run, CLK_DIV);
          if (!cur_word[FW-1]) exp_q.push_back(cur_resp);
          MISO = 1'b0;
        end
        ss_hi     = SS_n ? ss_hi + 1 : 0;
        prev_sclk = SCLK;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(rd_ptr == wr_ptr && !busy && !in_frame && exp_q.size() == 0) && n < budget) begin
      @(negedge HCLK);
      #1;
      n++;
    end
    chk("idle_timeout", n < budget, 1);
  endtask

  // main sequence
  initial begin
    int n0, f0, n, err, n_reads;
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] data, resp;

    repeat (3) @(negedge HCLK);
    #1;
    chk("rst_rd_en", TxFIFO_rd_en, 0);
    chk("rst_wr_en", RxFIFO_wr_en, 0);
    chk("rst_rx_data", DATA_to_RxFIFO, 0);
    chk("rst_sclk", SCLK, 0);
    chk("rst_ss_n", SS_n, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_dbg, IDLE);
    HRESET = 1'b0;
    repeat (2) @(negedge HCLK);
    #1;

    // single write frame
    n0 = n_push;
    f0 = frames;
    push_word({1'b1, 8'hA5, 32'hDEADBEEF}, $urandom);
    wait_idle(2000);
    chk("t1_no_push", n_push, n0);
    chk("t1_frames", frames, f0 + 1);

    // single read frame
    n0 = n_push;
    push_word({1'b0, 8'h3C, 32'h0}, 32'h12345678);
    wait_idle(2000);
    chk("t2_one_push", n_push, n0 + 1);

    // RxFIFO backpressure
    RxFIFO_full = 1'b1;
    addr = 8'($urandom_range(0, 255));
    push_word({1'b0, addr, 32'h0}, $urandom);
    n = 0;
    while (state_dbg != PUSH && n < 2000) begin
      @(negedge HCLK);
      #1;
      n++;
    end
    chk("t3_reach_push", n < 2000, 1);
    err = 0;
    repeat (20) begin
      @(negedge HCLK);
      #1;
      if (state_dbg != PUSH || !SS_n || SCLK || RxFIFO_wr_en) err++;
    end
    chk("t3_stall", err, 0);
    RxFIFO_full = 1'b0;
    @(negedge HCLK);
    #1;
    chk("t3_push_next", RxFIFO_wr_en, 1);
    wait_idle(2000);

    // back-to-back W, R, W
    n0 = n_push;
    f0 = frames;
    push_word({1'b1, 8'h11, 32'hCAFEF00D}, $urandom);
    push_word({1'b0, 8'h22, 32'h0}, $urandom);
    push_word({1'b1, 8'h33, 32'h0F0F1234}, $urandom);
    wait_idle(3000);
    chk("t4_frames", frames, f0 + 3);
    chk("t4_pushes", n_push, n0 + 1);

    // reset in the middle of a read frame
    n0 = n_push;
    f0 = frames;
    push_word({1'b0, 8'h5A, 32'h0}, $urandom);
    push_word({1'b1, 8'hC3, 32'h89ABCDEF}, $urandom);
    n = 0;
    while (!(in_frame && rises == 20) && n < 2000) begin
      @(negedge HCLK);
      #1;
      n++;
    end
    chk("t5_reach_edge20", n < 2000, 1);
    HRESET = 1'b1;
    #1;
    chk("t5_ss_n", SS_n, 1);
    chk("t5_sclk", SCLK, 0);
    chk("t5_busy", busy, 0);
    chk("t5_state", state_dbg, IDLE);
    repeat (2) @(negedge HCLK);
    #1;
    HRESET = 1'b0;
    wait_idle(2000);
    chk("t5_no_push", n_push, n0);
    chk("t5_clean_frame", frames, f0 + 1);

    // idle with an empty TxFIFO
    err = 0;
    repeat (100) begin
      @(negedge HCLK);
      #1;
      if (TxFIFO_rd_en || !SS_n || busy) err++;
    end
    chk("t6_idle", err, 0);

    // randomized traffic
    n0 = n_push;
    n_reads = 0;
    for (int i = 0; i < 10; i++) begin
      rw   = 1'($urandom_range(0, 1));
      addr = 8'($urandom_range(0, 255));
      data = $urandom;
      resp = $urandom;
      if (!rw) n_reads++;
      push_word({rw, addr, data}, resp);
      repeat ($urandom_range(0, 200)) @(negedge HCLK);
      #1;
    end
    wait_idle(6000);
    chk("rand_pushes", n_push, n0 + n_reads);

    chk("protocol", proto_err, 0);
    chk("sclk_duty", duty_err, 0);
    chk("ss_gap", gap_err, 0);
    chk("pop_empty", pop_err, 0);
    chk("exp_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
